rs232_frame_writer: RTL and testbench
=====================================

Name: rs232_frame_writer

Overview:
- Sits between the RS232 byte receiver and the VGA frame buffer / pixel fetch stage.
- Consumes the received byte stream and hunts for a 2-byte sync header.
- Writes the following H_PIX*V_PIX pixel bytes sequentially into a double-banked frame buffer.
- Flips the display bank on each complete frame, so VGA never scans out a half-written image.

Parameters:
- H_PIX, 160, pixels per line
- V_PIX, 120, lines per frame
- ADDR_W, 15, pixel address width; must satisfy 2^ADDR_W >= H_PIX*V_PIX
- SYNC0, 8'hAA, first header byte
- SYNC1, 8'h55, second header byte
- TIMEOUT, 2000000, idle cycles allowed between bytes inside a frame before abort

Ports:
- avm_clk  in  1  system clock (shared with RS232 and VGA stages)
- avm_rst  in  1  asynchronous, active-high reset
- i_byte_valid  in  1  one-cycle strobe: i_byte holds a new received byte
- i_byte  in  8  received byte
- o_wr_en  out  1  frame-buffer write strobe
- o_wr_addr  out  ADDR_W+1  {bank, pixel index}; MSB is the write bank
- o_wr_data  out  8  pixel value to write
- o_disp_bank  out  1  bank the VGA stage reads from
- o_frame_done  out  1  one-cycle pulse when a full frame has been written
- o_err  out  1  one-cycle pulse on timeout abort
- o_busy  out  1  high while in DATA state
- o_frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Clock and reset:
  - One clock domain (avm_clk).
  - All state registers use avm_rst asynchronously, active-high.
- Reset values:
  - State = HUNT0; pixel index = 0; timeout counter = 0.
  - o_wr_en = 0, o_wr_addr = 0, o_wr_data = 0.
  - o_disp_bank = 0, o_frame_done = 0, o_err = 0, o_busy = 0, o_frame_cnt = 0.
- Write bank: always ~o_disp_bank.
- FSM states: HUNT0, HUNT1, DATA.
- HUNT0:
  - Valid byte == SYNC0 -> HUNT1.
  - Any other byte: stay in HUNT0.
- HUNT1:
  - Valid byte == SYNC1 -> DATA, pixel index cleared to 0, timeout counter cleared.
  - Valid byte == SYNC0 -> stay in HUNT1 (handles AA AA 55).
  - Any other byte -> HUNT0.
- DATA, for each valid byte:
  - Registered write: the cycle after i_byte_valid, o_wr_en = 1 for exactly one cycle.
  - o_wr_addr = {~o_disp_bank, index}, o_wr_data = byte. Latency is 1 cycle.
  - Index increments after each byte.
  - The byte value is not inspected: 8'hAA and 8'h55 inside DATA are pixels, not a resync.
- Frame completion, when the byte taken is index H_PIX*V_PIX-1:
  - o_frame_done pulses in the same cycle as that final o_wr_en.
  - o_disp_bank toggles in that same cycle. The final write still carries the old write bank, since the address is registered before the toggle.
  - o_frame_cnt increments; state -> HUNT0.
- Timeout:
  - In DATA, the counter increments every cycle without i_byte_valid and clears on each valid byte.
  - When it reaches TIMEOUT-1: o_err pulses, state -> HUNT0, o_disp_bank unchanged, o_frame_cnt unchanged.
  - A partial frame stays in the hidden bank and is simply overwritten later.
- Simultaneous events: if a valid byte arrives in the cycle the counter would hit TIMEOUT-1, the byte wins. It is written and there is no abort.
- o_busy = 1 exactly while state == DATA.
- Back-to-back bytes: i_byte_valid may be high on consecutive cycles; every byte produces one write and none are dropped.
- Reset mid-frame:
  - Outputs return to reset values immediately (asynchronously), including o_disp_bank = 0.
  - The partial frame is discarded.
- Index arithmetic: unsigned ADDR_W bits; it never exceeds H_PIX*V_PIX-1.

Test Plan:
- Bench params for all scenarios: H_PIX=4, V_PIX=2, ADDR_W=3, TIMEOUT=16.
- Basic frame: send AA 55 then 01..08 on alternate cycles -> eight writes, addr {1,0}..{1,7}, data 01..08. o_frame_done on the 8th write; o_disp_bank 0->1; o_frame_cnt=1.
- Header hunting: send 12 AA AA 55 followed by 8 bytes -> writes start only after 55. Data 8'hAA/8'h55 inside the payload is written as pixels with no resync.
- Second frame: repeat the basic frame -> writes use bank 0 (addr MSB=0); o_disp_bank 1->0; o_frame_cnt=2.
- Timeout: AA 55 then 3 bytes, then 16 idle cycles -> o_err pulse, o_busy=0, o_disp_bank and o_frame_cnt unchanged. A new AA 55 + 8 bytes then completes normally from index 0.
- Boundary race and back-to-back: byte arriving exactly on idle cycle 15 -> written, no o_err. Eight payload bytes on consecutive cycles -> eight consecutive o_wr_en cycles.
- Reset mid-operation: assert avm_rst after the 5th payload byte -> o_wr_en=0, o_busy=0, o_disp_bank=0 immediately. After release, a full frame completes with o_frame_cnt=1.

Source files
------------

// File: rtl/rs232_frame_writer.sv
// Frame writer between the RS232 byte receiver and the VGA frame buffer.
// Hunts for a two-byte sync header, then writes one frame of pixels into the hidden bank.
module rs232_frame_writer #(
  parameter int unsigned H_PIX   = 160,
  parameter int unsigned V_PIX   = 120,
  parameter int unsigned ADDR_W  = 15,
  parameter logic [7:0]  SYNC0   = 8'hAA,
  parameter logic [7:0]  SYNC1   = 8'h55,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_wr_en,
  output logic [ADDR_W:0]   o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_disp_bank,
  output logic              o_frame_done,
  output logic              o_err,
  output logic              o_busy,
  output logic [7:0]        o_frame_cnt
);

  localparam int unsigned       TO_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(H_PIX * V_PIX - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    HUNT0,
    HUNT1,
    DATA
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [TO_W-1:0]   to_cnt;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state        <= HUNT0;
      idx          <= '0;
      to_cnt       <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_disp_bank  <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      case (state)
        HUNT0: begin
          if (i_byte_valid && i_byte == SYNC0) state <= HUNT1;
        end
        HUNT1: begin
          if (i_byte_valid) begin
            if (i_byte == SYNC1) begin
              state  <= DATA;
              idx    <= '0;
              to_cnt <= '0;
              o_busy <= 1'b1;
            end else if (i_byte != SYNC0) begin
              state <= HUNT0;
            end
          end
        end
        DATA: begin
          if (i_byte_valid) begin
            // Address uses the pre-toggle bank, so the last pixel lands in the hidden bank.
            o_wr_en   <= 1'b1;
            o_wr_addr <= {~o_disp_bank, idx};
            o_wr_data <= i_byte;
            to_cnt    <= '0;
            if (idx == LAST_IDX) begin
              idx          <= '0;
              o_frame_done <= 1'b1;
              o_disp_bank  <= ~o_disp_bank;
              o_frame_cnt  <= o_frame_cnt + 8'd1;
              o_busy       <= 1'b0;
              state        <= HUNT0;
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end else if (to_cnt == TO_LAST) begin
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= HUNT0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: begin
          state  <= HUNT0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_frame_writer.sv
// Bench for rs232_frame_writer: a basic-frame vector table, directed corner sequences,
// and random byte streams, all checked against a behavioural frame model.
module tb_rs232_frame_writer;

  localparam int H = 4, V = 2, AW = 3, TO = 16;
  localparam int FRAME = H * V;
  localparam int WB = 1 << AW;
  localparam logic [7:0] S0 = 8'hAA, S1 = 8'h55;

  logic          avm_clk = 1'b0;
  logic          avm_rst;
  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          o_wr_en;
  logic [AW:0]   o_wr_addr;
  logic [7:0]    o_wr_data;
  logic          o_disp_bank, o_frame_done, o_err, o_busy;
  logic [7:0]    o_frame_cnt;

  rs232_frame_writer #(
    .H_PIX(H), .V_PIX(V), .ADDR_W(AW), .SYNC0(S0), .SYNC1(S1), .TIMEOUT(TO)
  ) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst),
    .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_disp_bank(o_disp_bank), .o_frame_done(o_frame_done), .o_err(o_err),
    .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
  );

  always #5 avm_clk = ~avm_clk;

  int checks = 0, failures = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Behavioural model: frame phase, pixel count and idle run length.
  bit m_in_frame, m_seen_sync0, m_bank;
  int m_pix, m_idle, m_cnt;
  bit e_wr, e_done, e_err;
  int e_addr, e_data;
  int err_seen, wr_seen;

  task automatic model_reset();
    m_in_frame = 0; m_seen_sync0 = 0; m_bank = 0;
    m_pix = 0; m_idle = 0; m_cnt = 0;
    e_wr = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    e_wr = 0; e_done = 0; e_err = 0;
    if (m_in_frame) begin
      if (v) begin
        e_wr   = 1;
        e_addr = (m_bank ? 0 : WB) + m_pix;
        e_data = b;
        m_pix++;
        m_idle = 0;
        if (m_pix == FRAME) begin
          e_done = 1;
          m_bank = !m_bank;
          m_cnt  = (m_cnt + 1) % 256;
          m_in_frame = 0;
          m_seen_sync0 = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TO - 1) begin
          e_err = 1;
          m_in_frame = 0;
          m_seen_sync0 = 0;
        end
      end
    end else if (v) begin
      if (m_seen_sync0 && b == S1) begin
        m_in_frame = 1; m_pix = 0; m_idle = 0; m_seen_sync0 = 0;
      end else begin
        m_seen_sync0 = (b == S0);
      end
    end
  endtask

  task automatic compare_model();
    chk("wr_en", int'(o_wr_en), int'(e_wr));
    chk("frame_done", int'(o_frame_done), int'(e_done));
    chk("err", int'(o_err), int'(e_err));
    chk("busy", int'(o_busy), int'(m_in_frame));
    chk("disp_bank", int'(o_disp_bank), int'(m_bank));
    chk("frame_cnt", int'(o_frame_cnt), m_cnt);
    if (e_wr) begin
      chk("wr_addr", int'(o_wr_addr), e_addr);
      chk("wr_data", int'(o_wr_data), e_data);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic step(input bit v, input logic [7:0] b);
    i_byte_valid = v;
    i_byte = b;
    @(posedge avm_clk);
    model_step(v, b);
    @(negedge avm_clk);
    compare_model();
    err_seen += int'(o_err);
    wr_seen  += int'(o_wr_en);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'($urandom));
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, ".wr_en"}, int'(o_wr_en), 0);
    chk({tag, ".wr_addr"}, int'(o_wr_addr), 0);
    chk({tag, ".wr_data"}, int'(o_wr_data), 0);
    chk({tag, ".disp_bank"}, int'(o_disp_bank), 0);
    chk({tag, ".frame_done"}, int'(o_frame_done), 0);
    chk({tag, ".err"}, int'(o_err), 0);
    chk({tag, ".busy"}, int'(o_busy), 0);
    chk({tag, ".frame_cnt"}, int'(o_frame_cnt), 0);
  endtask

  // Asserts reset between clock edges and checks outputs clear without a clock.
  task automatic async_reset(string tag);
    #2 avm_rst = 1'b1;
    #1 check_reset_outputs(tag);
    model_reset();
    i_byte_valid = 1'b0;
    @(negedge avm_clk);
    @(negedge avm_clk);
    avm_rst = 1'b0;
  endtask

  typedef struct {
    bit         v;
    logic [7:0] b;
    bit         wr_en;
    int         addr;
    int         data;
    bit         done;
    bit         bank;
    int         cnt;
    bit         busy;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // Basic frame: AA 55 then 01..08, each followed by one idle cycle.
    tbl[0] = '{1, 8'hAA, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 8'h55, 0, 0, 0, 0, 0, 0, 1};
    tbl[3] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 8; k++) begin
      tbl[4 + 2*k] = '{1, 8'(k + 1), 1, 8 + k, k + 1, k == 7, k == 7, (k == 7) ? 1 : 0, k != 7};
      tbl[5 + 2*k] = '{0, 8'h00, 0, 0, 0, 0, k == 7, (k == 7) ? 1 : 0, k != 7};
    end

    avm_rst = 1'b1;
    i_byte_valid = 1'b0;
    i_byte = 8'h00;
    err_seen = 0;
    wr_seen = 0;
    model_reset();
    #3 check_reset_outputs("reset");
    @(negedge avm_clk);
    @(negedge avm_clk);
    avm_rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      i_byte_valid = tbl[i].v;
      i_byte = tbl[i].b;
      @(posedge avm_clk);
      model_step(tbl[i].v, tbl[i].b);
      @(negedge avm_clk);
      chk("tbl.wr_en", int'(o_wr_en), int'(tbl[i].wr_en));
      if (tbl[i].wr_en) begin
        chk("tbl.wr_addr", int'(o_wr_addr), tbl[i].addr);
        chk("tbl.wr_data", int'(o_wr_data), tbl[i].data);
      end
      chk("tbl.frame_done", int'(o_frame_done), int'(tbl[i].done));
      chk("tbl.disp_bank", int'(o_disp_bank), int'(tbl[i].bank));
      chk("tbl.frame_cnt", int'(o_frame_cnt), tbl[i].cnt);
      chk("tbl.busy", int'(o_busy), int'(tbl[i].busy));
      chk("tbl.err", int'(o_err), 0);
    end

    // Header hunting; sync bytes inside the payload are pixels. Second frame writes bank 0.
    send(8'h12); send(8'hAA); send(8'hAA); send(8'h55);
    wr_seen = 0;
    send(8'hAA); send(8'h55); send(8'h03); send(8'h04);
    send(8'hAA); send(8'h55); send(8'h07); send(8'h08);
    chk("hunt.consecutive_writes", wr_seen, 8);
    chk("hunt.disp_bank", int'(o_disp_bank), 0);
    chk("hunt.frame_cnt", int'(o_frame_cnt), 2);
    idle(3);

    // Timeout after three bytes, then a clean frame from index 0.
    send(S0); send(S1); send(8'h31); send(8'h32); send(8'h33);
    err_seen = 0;
    idle(16);
    chk("timeout.err_pulses", err_seen, 1);
    chk("timeout.busy", int'(o_busy), 0);
    chk("timeout.disp_bank", int'(o_disp_bank), 0);
    chk("timeout.frame_cnt", int'(o_frame_cnt), 2);
    send(S0); send(S1);
    for (int k = 0; k < 8; k++) send(8'(8'h40 + k));
    chk("after_timeout.frame_cnt", int'(o_frame_cnt), 3);
    chk("after_timeout.disp_bank", int'(o_disp_bank), 1);

    // Byte on the last idle cycle before abort wins; remaining bytes back-to-back.
    send(S0); send(S1); send(8'h61);
    err_seen = 0;
    idle(TO - 2);
    send(8'h62);
    wr_seen = 0;
    for (int k = 0; k < 6; k++) send(8'(8'h63 + k));
    chk("race.err_pulses", err_seen, 0);
    chk("race.consecutive_writes", wr_seen, 6);
    chk("race.frame_cnt", int'(o_frame_cnt), 4);

    // Reset after the fifth payload byte, then a full frame.
    send(S0); send(S1);
    for (int k = 0; k < 5; k++) send(8'(8'h70 + k));
    chk("pre_reset.wr_en", int'(o_wr_en), 1);
    async_reset("midreset");
    send(S0); send(S1);
    for (int k = 0; k < 8; k++) send(8'(8'h80 + k));
    chk("post_reset.frame_cnt", int'(o_frame_cnt), 1);
    chk("post_reset.disp_bank", int'(o_disp_bank), 1);

    // Random byte streams biased towards sync bytes, with occasional long gaps.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) idle(TO + 2);
      else if (r < 45) step(1'b0, 8'($urandom));
      else begin
        case ($urandom_range(0, 3))
          0: send(S0);
          1: send(S1);
          default: send(8'($urandom));
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
